seq_divide: RTL and testbench

//  Parametrised multi-cycle restoring divider for the camera pixel path.

---
 rtl/seq_divide.sv | 122 ++++++++++++
 tb/tb_seq_divide.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divide.sv
// Multi-cycle restoring divider: quot = floor(num * 2^FRAC / den), one quotient bit per clock.
// Optional remainder output is enabled by defining DIV_REM_EN.
module seq_divide #(
    parameter int W    = 8,
    parameter int FRAC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        num,
    input  logic [W-1:0]        den,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W+FRAC-1:0]   quot,
    output logic                div_zero
`ifdef DIV_REM_EN
    ,
    output logic [W-1:0]        rem
`endif
);

    localparam int QW = W + FRAC;
    localparam int CW = $clog2(QW + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(QW - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    den_q;
    logic [QW-1:0]   dvd_q;
    logic [W-1:0]    r_q;
    logic [CW-1:0]   cnt;

    logic [W:0]      t;
    logic            qbit;
    logic [W-1:0]    r_next;

    // The partial remainder always stays below den, so W bits hold it; the
    // extra trial bit only matters for the compare.
    always_comb begin
        t      = {r_q, dvd_q[QW-1]};
        qbit   = (t >= {1'b0, den_q});
        r_next = qbit ? (t[W-1:0] - den_q) : t[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            quot      <= '0;
            div_zero  <= 1'b0;
            den_q     <= '0;
            dvd_q     <= '0;
            r_q       <= '0;
            cnt       <= '0;
`ifdef DIV_REM_EN
            rem       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        den_q    <= den;
                        dvd_q    <= QW'(num) << FRAC;
                        r_q      <= '0;
                        cnt      <= '0;
                        if (den == '0) begin
                            state    <= DONE;
                            quot     <= '1;
                            div_zero <= 1'b1;
`ifdef DIV_REM_EN
                            rem      <= num;
`endif
                        end else begin
                            state    <= CALC;
                            div_zero <= 1'b0;
                        end
                    end
                end

                CALC: begin
                    dvd_q <= dvd_q << 1;
                    r_q   <= r_next;
                    quot  <= {quot[QW-2:0], qbit};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
`ifdef DIV_REM_EN
                        rem       <= r_next;
`endif
                    end
                end

                // A divide-by-zero enters DONE straight from IDLE and raises
                // out_valid one cycle later; hand-off needs a visible result.
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divide.sv
// Directed vector table plus corner-case sequences for seq_divide (W=8, FRAC=1),
// and a random sweep on a W=12, FRAC=4 instance.
module tb_seq_divide;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  num;
    logic [7:0]  den;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  quot;
    logic        div_zero;
`ifdef DIV_REM_EN
    logic [7:0]  rem;
`endif

    logic        in_valid12;
    logic        in_ready12;
    logic [11:0] num12;
    logic [11:0] den12;
    logic        out_valid12;
    logic        out_ready12;
    logic [15:0] quot12;
    logic        div_zero12;
`ifdef DIV_REM_EN
    logic [11:0] rem12;
`endif

    int n_checks;
    int n_fail;

    seq_divide #(.W(8), .FRAC(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .div_zero  (div_zero)
`ifdef DIV_REM_EN
        ,
        .rem       (rem)
`endif
    );

    seq_divide #(.W(12), .FRAC(4)) u_dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid12),
        .in_ready  (in_ready12),
        .num       (num12),
        .den       (den12),
        .out_valid (out_valid12),
        .out_ready (out_ready12),
        .quot      (quot12),
        .div_zero  (div_zero12)
`ifdef DIV_REM_EN
        ,
        .rem       (rem12)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] n;
        logic [7:0] d;
        logic [8:0] q;
        logic       dz;
        logic [7:0] r;
        logic       early;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns with the result visible (or the bound expired).
    task automatic applyStimulus(input logic [7:0] n, input logic [7:0] d, input logic early,
                                 output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        num       = n;
        den       = d;
        in_valid  = 1'b1;
        out_ready = early;
        @(posedge clk); #1;
        checkOutput("in_ready_after_accept", {31'b0, in_ready}, 32'd0);
        in_valid = early;
        num      = 8'($urandom);
        den      = 8'($urandom);
        lat      = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic handOff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("handoff_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("handoff_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int guard;
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        num         = '0;
        den         = '0;
        in_valid12  = 1'b0;
        out_ready12 = 1'b0;
        num12       = '0;
        den12       = '0;

        vecs[0]  = '{8'd200, 8'd7,   9'd57,   1'b0, 8'd1,  1'b0};
        vecs[1]  = '{8'd255, 8'd1,   9'h1FE,  1'b0, 8'd0,  1'b0};
        vecs[2]  = '{8'd3,   8'd10,  9'd0,    1'b0, 8'd6,  1'b1};
        vecs[3]  = '{8'd42,  8'd0,   9'h1FF,  1'b1, 8'd42, 1'b0};
        vecs[4]  = '{8'd10,  8'd5,   9'd4,    1'b0, 8'd0,  1'b0};
        vecs[5]  = '{8'd0,   8'd9,   9'd0,    1'b0, 8'd0,  1'b1};
        vecs[6]  = '{8'd255, 8'd255, 9'd2,    1'b0, 8'd0,  1'b0};
        vecs[7]  = '{8'd1,   8'd255, 9'd0,    1'b0, 8'd2,  1'b1};
        vecs[8]  = '{8'd128, 8'd2,   9'd128,  1'b0, 8'd0,  1'b0};
        vecs[9]  = '{8'd77,  8'd13,  9'd11,   1'b0, 8'd11, 1'b0};
        vecs[10] = '{8'd254, 8'd3,   9'd169,  1'b0, 8'd1,  1'b1};
        vecs[11] = '{8'd0,   8'd0,   9'h1FF,  1'b1, 8'd0,  1'b1};
        vecs[12] = '{8'd1,   8'd1,   9'd2,    1'b0, 8'd0,  1'b0};
        vecs[13] = '{8'd255, 8'd2,   9'd255,  1'b0, 8'd0,  1'b0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_quot", {23'b0, quot}, 32'd0);
        checkOutput("reset_div_zero", {31'b0, div_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].n, vecs[i].d, vecs[i].early, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, (vecs[i].d == 8'd0) ? 32'd1 : 32'd9);
            checkOutput($sformatf("vec%0d_quot", i), {23'b0, quot}, {23'b0, vecs[i].q});
            checkOutput($sformatf("vec%0d_div_zero", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
`ifdef DIV_REM_EN
            checkOutput($sformatf("vec%0d_rem", i), {24'b0, rem}, {24'b0, vecs[i].r});
`endif
            handOff();
        end

        // Consumer stalls for 20 cycles: result must hold and no new op may enter.
        applyStimulus(8'd200, 8'd7, 1'b0, lat);
        checkOutput("stall_latency", lat, 32'd9);
        in_valid = 1'b1;
        num      = 8'd5;
        den      = 8'd1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("stall_cycle%0d", c), {21'b0, out_valid, in_ready, quot},
                        {21'b0, 1'b1, 1'b0, 9'd57});
        end
        in_valid = 1'b0;
        handOff();

        // Reset in the middle of a division drops it without a result.
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        num      = 8'd200;
        den      = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midreset_quot", {23'b0, quot}, 32'd0);
        checkOutput("midreset_in_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_release_in_ready", {31'b0, in_ready}, 32'd1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("no_stale_cycle%0d", c), {31'b0, out_valid}, 32'd0);
        end
        applyStimulus(8'd100, 8'd3, 1'b0, lat);
        checkOutput("after_reset_latency", lat, 32'd9);
        checkOutput("after_reset_quot", {23'b0, quot}, 32'd66);
        checkOutput("after_reset_div_zero", {31'b0, div_zero}, 32'd0);
`ifdef DIV_REM_EN
        checkOutput("after_reset_rem", {24'b0, rem}, 32'd2);
`endif
        handOff();

        // Random sweep on the wide instance against floor(num*16/den).
        for (int i = 0; i < 300; i++) begin
            logic [11:0] n;
            logic [11:0] d;
            int unsigned scaled;
            int unsigned exp_q;
            int unsigned exp_r;
            n = 12'($urandom_range(0, 4095));
            if (i % 17 == 0)
                d = 12'd0;
            else if (i % 3 == 0)
                d = 12'($urandom_range(1, 15));
            else
                d = 12'($urandom_range(1, 4095));
            scaled = 32'(n) * 16;
            exp_q  = (d == 12'd0) ? 32'hFFFF : scaled / 32'(d);
            exp_r  = (d == 12'd0) ? 32'(n) : scaled % 32'(d);

            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            guard = 0;
            while (!in_ready12 && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            checkOutput("sweep_in_ready", {31'b0, in_ready12}, 32'd1);
            num12      = n;
            den12      = d;
            in_valid12 = 1'b1;
            @(posedge clk); #1;
            in_valid12 = 1'b0;
            num12      = 12'($urandom);
            den12      = 12'($urandom);
            lat = 0;
            while (!out_valid12 && lat < 64) begin
                @(posedge clk); #1;
                lat++;
            end
            checkOutput($sformatf("sweep%0d_latency", i), lat, (d == 12'd0) ? 32'd1 : 32'd16);
            checkOutput($sformatf("sweep%0d_quot n=%0d d=%0d", i, n, d), {16'b0, quot12}, exp_q);
            checkOutput($sformatf("sweep%0d_div_zero", i), {31'b0, div_zero12}, {31'b0, (d == 12'd0)});
`ifdef DIV_REM_EN
            checkOutput($sformatf("sweep%0d_rem", i), {20'b0, rem12}, exp_r);
`endif
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            out_ready12 = 1'b1;
            @(posedge clk); #1;
            out_ready12 = 1'b0;
            checkOutput($sformatf("sweep%0d_handoff", i), {31'b0, out_valid12}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
